// File: rtl/fir_transient_monitor.sv
// fir_transient_monitor: observes the fir_filter output stream after a start
// pulse and records peak value/index, settle index and settled/timeout status.
// Optional macro FIR_MON_MIN_TRACK_EN adds min_val/min_idx undershoot tracking.
module fir_transient_monitor #(
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16,
  parameter int SETTLE_WINDOW = 16,
  parameter int MAX_SAMPLES   = 10000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic [DATA_WIDTH-1:0] target,
  input  logic [DATA_WIDTH-1:0] tol,
  output logic                  busy,
  output logic                  done,
  output logic                  settled,
  output logic                  timeout,
  output logic [DATA_WIDTH-1:0] peak_val,
  output logic [CNT_WIDTH-1:0]  peak_idx,
`ifdef FIR_MON_MIN_TRACK_EN
  output logic [DATA_WIDTH-1:0] min_val,
  output logic [CNT_WIDTH-1:0]  min_idx,
`endif
  output logic [CNT_WIDTH-1:0]  settle_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] tgt_r;
  logic [DATA_WIDTH-1:0] tol_r;
  logic [CNT_WIDTH-1:0]  idx;
  logic [CNT_WIDTH-1:0]  band_cnt;

  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH:0]   abs_diff;
  logic                  in_band;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  hit_settle;
  logic                  hit_last;
  logic                  new_peak;
`ifdef FIR_MON_MIN_TRACK_EN
  logic                  new_min;
`endif

  // Band test in DATA_WIDTH+1 bits so extreme sample/target pairs cannot wrap
  always_comb begin
    diff       = {sample_in[DATA_WIDTH-1], sample_in} - {tgt_r[DATA_WIDTH-1], tgt_r};
    abs_diff   = diff[DATA_WIDTH] ? -diff : diff;
    in_band    = abs_diff <= {1'b0, tol_r};
    cnt_inc    = band_cnt + CNT_WIDTH'(1);
    hit_settle = in_band && (cnt_inc == CNT_WIDTH'(SETTLE_WINDOW));
    hit_last   = idx == CNT_WIDTH'(MAX_SAMPLES - 1);
    new_peak   = (idx == '0) || ($signed(sample_in) > $signed(peak_val));
`ifdef FIR_MON_MIN_TRACK_EN
    new_min    = (idx == '0) || ($signed(sample_in) < $signed(min_val));
`endif
  end

  // Measurement FSM with registered status and result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tgt_r      <= '0;
      tol_r      <= '0;
      idx        <= '0;
      band_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      settled    <= 1'b0;
      timeout    <= 1'b0;
      peak_val   <= '0;
      peak_idx   <= '0;
      settle_idx <= '0;
`ifdef FIR_MON_MIN_TRACK_EN
      min_val    <= '0;
      min_idx    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tgt_r      <= target;
            tol_r      <= tol;
            idx        <= '0;
            band_cnt   <= '0;
            settled    <= 1'b0;
            timeout    <= 1'b0;
            peak_val   <= '0;
            peak_idx   <= '0;
            settle_idx <= '0;
`ifdef FIR_MON_MIN_TRACK_EN
            min_val    <= '0;
            min_idx    <= '0;
`endif
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (sample_valid) begin
            idx <= idx + CNT_WIDTH'(1);
            if (new_peak) begin
              peak_val <= sample_in;
              peak_idx <= idx;
            end
`ifdef FIR_MON_MIN_TRACK_EN
            if (new_min) begin
              min_val <= sample_in;
              min_idx <= idx;
            end
`endif
            if (in_band) begin
              band_cnt <= cnt_inc;
              if (band_cnt == '0) settle_idx <= idx;
            end else begin
              band_cnt <= '0;
            end
            // Settle is checked first so it wins when it lands on the last budgeted sample
            if (hit_settle) begin
              settled <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else if (hit_last) begin
              timeout <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
